// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared single-precision float constants and divider FSM encodings
package float_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Quotient width: one integer bit, 23 fraction bits, guard, and one spare
    // bit so that a quotient below 1.0 still yields a full mantissa plus guard.
    localparam int          Q_W     = 26;
    localparam logic [4:0]  DIV_LAST = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/float_div_if.sv
// rtl/float_div_if.sv - operand/result handshake bundle for the float divider
interface float_div_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] ain;
    logic [31:0] bin;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        dz;
    logic        ovf;
    logic        unf;

    modport slave (
        input  in_valid, ain, bin, out_ready,
        output in_ready, out, out_valid, dz, ovf, unf
    );

    modport master (
        output in_valid, ain, bin, out_ready,
        input  in_ready, out, out_valid, dz, ovf, unf
    );

endinterface

// File: rtl/float_div_mant_core.sv
// rtl/float_div_mant_core.sv - radix-2 restoring mantissa divider, one quotient bit per clock
module float_div_mant_core
    import float_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [23:0]    ma,
    input  logic [23:0]    mb,
    output logic [Q_W-1:0] q,
    output logic           done
);

    logic [24:0] rem;
    logic [23:0] mb_r;
    logic [4:0]  cnt;
    logic        busy;
    logic        ge;
    logic [24:0] rem_sub;

    // Partial remainder never reaches 2*mb, so 25 bits hold it before each compare.
    always_comb begin
        ge      = (rem >= {1'b0, mb_r});
        rem_sub = ge ? (rem - {1'b0, mb_r}) : rem;
    end

    // Load on start, then shift one quotient bit in MSB-first per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            mb_r <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            q    <= '0;
        end else if (start) begin
            rem  <= {1'b0, ma};
            mb_r <= mb;
            cnt  <= '0;
            busy <= 1'b1;
            q    <= '0;
        end else if (busy) begin
            q   <= {q[Q_W-2:0], ge};
            rem <= {rem_sub[23:0], 1'b0};
            cnt <= cnt + 5'd1;
            if (cnt == DIV_LAST) begin
                busy <= 1'b0;
            end
        end
    end

    // High during the cycle whose closing edge produces the final quotient bit.
    always_comb begin
        done = busy && (cnt == DIV_LAST);
    end

endmodule

// File: rtl/float_div.sv
// rtl/float_div.sv - iterative IEEE-754 single-precision divider with valid/ready handshake
module float_div
    import float_pkg::*;
#(
    parameter bit          ROUND_EN = 1'b1,
    parameter logic [31:0] QNAN_VAL = 32'h7FC00000
)
(
    input  logic        clk,
    input  logic        rst_n,
    float_div_if.slave  bus
);

    div_state_t state;
    div_state_t state_next;

    logic        accept;
    logic        start;
    logic        core_done;
    logic [Q_W-1:0] q;

    logic              sign_in;
    logic [EXP_W-1:0]  ea_in;
    logic [EXP_W-1:0]  eb_in;
    logic [23:0]       ma_in;
    logic [23:0]       mb_in;

    logic        spec_hit;
    logic        spec_dz;
    logic [31:0] spec_out;

    logic              sign_r;
    logic [EXP_W-1:0]  ea_r;
    logic [EXP_W-1:0]  eb_r;
    logic [31:0]       out_r;
    logic              dz_r;
    logic              ovf_r;
    logic              unf_r;

    logic signed [9:0] e_n;
    logic [MAN_W-1:0]  man_n;
    logic              guard;
    logic [MAN_W:0]    man_rnd;
    logic [31:0]       norm_out;
    logic              norm_ovf;
    logic              norm_unf;

    // Unpack operands straight off the bus; they are only used on the accept cycle.
    always_comb begin
        sign_in = bus.ain[31] ^ bus.bin[31];
        ea_in   = bus.ain[MAN_W +: EXP_W];
        eb_in   = bus.bin[MAN_W +: EXP_W];
        ma_in   = {1'b1, bus.ain[MAN_W-1:0]};
        mb_in   = {1'b1, bus.bin[MAN_W-1:0]};
        accept  = bus.in_valid && (state == ST_IDLE);
    end

    // Special operands resolve without iterating; first matching rule wins.
    always_comb begin
        spec_hit = 1'b1;
        spec_dz  = 1'b0;
        spec_out = '0;
        if (ea_in == EXP_MAX || eb_in == EXP_MAX) begin
            spec_out = QNAN_VAL;
        end else if (ea_in == '0 && eb_in == '0) begin
            spec_out = QNAN_VAL;
        end else if (eb_in == '0) begin
            spec_out = POS_INF | {sign_in, 31'd0};
            spec_dz  = 1'b1;
        end else if (ea_in == '0) begin
            spec_out = '0;
        end else begin
            spec_hit = 1'b0;
        end
    end

    float_div_mant_core u_mant_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ma    (ma_in),
        .mb    (mb_in),
        .q     (q),
        .done  (core_done)
    );

    // Normalise the quotient, round on the guard bit and range-check the exponent.
    always_comb begin
        e_n = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + $signed(10'(BIAS));
        if (q[25]) begin
            man_n = q[24:2];
            guard = q[1];
        end else begin
            man_n = q[23:1];
            guard = q[0];
            e_n   = e_n - 10'sd1;
        end
        man_rnd = {1'b0, man_n} + {{MAN_W{1'b0}}, (ROUND_EN && guard)};
        if (man_rnd[MAN_W]) begin
            e_n = e_n + 10'sd1;
        end
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (e_n >= 10'sd255) begin
            norm_out = POS_INF | {sign_r, 31'd0};
            norm_ovf = 1'b1;
        end else if (e_n <= 10'sd0) begin
            norm_out = '0;
            norm_unf = 1'b1;
        end else begin
            norm_out = {sign_r, e_n[7:0], man_rnd[MAN_W-1:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = spec_hit ? ST_DONE : ST_DIV;
            ST_DIV:  if (core_done)     state_next = ST_NORM;
            ST_NORM:                    state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake strobes and the mantissa core kick-off.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        start         = accept && !spec_hit;
    end

    // Operand latch on accept, result and flag capture on special or NORM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r <= 1'b0;
            ea_r   <= '0;
            eb_r   <= '0;
            out_r  <= '0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else if (accept) begin
            sign_r <= sign_in;
            ea_r   <= ea_in;
            eb_r   <= eb_in;
            dz_r   <= spec_dz;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            if (spec_hit) begin
                out_r <= spec_out;
            end
        end else if (state == ST_NORM) begin
            out_r <= norm_out;
            ovf_r <= norm_ovf;
            unf_r <= norm_unf;
        end
    end

    // Result and flags are held in registers and only change on accept or NORM.
    always_comb begin
        bus.out = out_r;
        bus.dz  = dz_r;
        bus.ovf = ovf_r;
        bus.unf = unf_r;
    end

endmodule
